// File: rtl/visualiser_mode_ctrl_pkg.sv
// Shared definitions for the visualiser mode controller: state encoding,
// pixel width and hold-counter sizing.
package visualiser_mode_ctrl_pkg;

  localparam int RGB565_W = 16;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    LOUD   = 2'd1,
    HOLD   = 2'd2
  } vis_state_e;

  // A one-cycle hold still needs a 1-bit counter to hold the value 0.
  function automatic int hold_cnt_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/visualiser_mode_ctrl_hold_timer.sv
// Hold dwell counter: clear has priority over increment; tc flags the last hold cycle.
// Latency: count updates one cycle after clear/inc; tc is combinational from count. No backpressure.
module vis_hold_timer
  import visualiser_mode_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = hold_cnt_w(HOLD_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(HOLD_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/visualiser_mode_ctrl.sv
// Chooses between the normal visualiser and the loud image with level hysteresis,
// a minimum loud dwell and frame-aligned switching. Latency: oled_data 1 cycle. No backpressure.
module visualiser_mode_ctrl
  import visualiser_mode_ctrl_pkg::*;
#(
  parameter int LVL_W       = 5,
  parameter int PIX_W       = RGB565_W,
  parameter int ON_THRESH   = 10,
  parameter int OFF_THRESH  = 8,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int FRAME_LAST  = 6143
) (
  input  logic             basys_clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [LVL_W-1:0] volume,
  input  logic             volume_valid,
  input  logic [12:0]      pixel_index,
  input  logic [PIX_W-1:0] normal_data,
  input  logic [PIX_W-1:0] loud_data,
  output logic [PIX_W-1:0] oled_data,
  output logic             loud_active,
  output logic [7:0]       loud_events
);

  localparam int               CNT_W  = hold_cnt_w(HOLD_CYCLES);
  localparam logic [LVL_W-1:0] ON_LVL  = LVL_W'(ON_THRESH);
  localparam logic [LVL_W-1:0] OFF_LVL = LVL_W'(OFF_THRESH);

  if (OFF_THRESH > ON_THRESH || FRAME_LAST > 8191) begin : g_bad_param
    $error("visualiser_mode_ctrl: OFF_THRESH must not exceed ON_THRESH and FRAME_LAST must fit 13 bits");
  end

  vis_state_e       state;
  vis_state_e       state_next;
  logic             loud_req;
  logic             quiet_req;
  logic             enter_loud;
  logic             hold_clear;
  logic             hold_inc;
  logic             hold_tc;
  logic [CNT_W-1:0] hold_count;
  logic             want_loud;
  logic             loud_active_next;

  assign loud_req  = volume_valid && (volume >= ON_LVL);
  assign quiet_req = volume_valid && (volume < OFF_LVL);

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = NORMAL;
    end else begin
      unique case (state)
        NORMAL:  if (loud_req) state_next = LOUD;
        LOUD:    if (quiet_req) state_next = HOLD;
        HOLD: begin
          // A fresh loud sample wins over expiry in the same cycle.
          if (loud_req) begin
            state_next = LOUD;
          end else if (hold_tc) begin
            state_next = NORMAL;
          end
        end
        default: state_next = NORMAL;
      endcase
    end
  end

  // Counter only runs while staying in HOLD; any entry/exit leaves it at 0.
  assign hold_inc   = (state == HOLD) && (state_next == HOLD);
  assign hold_clear = !hold_inc;
  assign enter_loud = (state == NORMAL) && (state_next == LOUD);

  vis_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk   (basys_clock),
    .reset (reset),
    .clear (hold_clear),
    .inc   (hold_inc),
    .count (hold_count),
    .tc    (hold_tc)
  );

  assign want_loud        = (state != NORMAL);
  assign loud_active_next = (pixel_index == 13'd0) ? want_loud : loud_active;

  always_ff @(posedge basys_clock) begin
    if (reset) begin
      state       <= NORMAL;
      loud_active <= 1'b0;
      oled_data   <= '0;
      loud_events <= 8'd0;
    end else begin
      state       <= state_next;
      loud_active <= loud_active_next;
      oled_data   <= loud_active_next ? loud_data : normal_data;
      if (enter_loud && (loud_events != 8'hFF)) begin
        loud_events <= loud_events + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_visualiser_mode_ctrl.sv
// Directed bench for visualiser_mode_ctrl with a 16-cycle hold.
module tb_visualiser_mode_ctrl;

  localparam int HC = 16;

  logic        basys_clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [4:0]  volume;
  logic        volume_valid;
  logic [12:0] pixel_index;
  logic [15:0] normal_data;
  logic [15:0] loud_data;
  logic [15:0] oled_data;
  logic        loud_active;
  logic [7:0]  loud_events;

  int checks = 0;
  int errors = 0;

  always #5 basys_clock = ~basys_clock;

  visualiser_mode_ctrl #(
    .LVL_W       (5),
    .PIX_W       (16),
    .ON_THRESH   (10),
    .OFF_THRESH  (8),
    .HOLD_CYCLES (HC),
    .FRAME_LAST  (6143)
  ) dut (
    .basys_clock  (basys_clock),
    .reset        (reset),
    .enable       (enable),
    .volume       (volume),
    .volume_valid (volume_valid),
    .pixel_index  (pixel_index),
    .normal_data  (normal_data),
    .loud_data    (loud_data),
    .oled_data    (oled_data),
    .loud_active  (loud_active),
    .loud_events  (loud_events)
  );

  typedef struct {
    logic        en;
    logic        vv;
    logic [4:0]  vol;
    logic [12:0] pix;
    logic [15:0] nd;
    logic [15:0] ld;
    logic [1:0]  exp_state;
    logic        exp_active;
    logic [15:0] exp_oled;
    logic [7:0]  exp_events;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic vv, input logic [4:0] vol,
                       input logic [12:0] pix, input logic [15:0] nd, input logic [15:0] ld);
    enable       = en;
    volume_valid = vv;
    volume       = vol;
    pixel_index  = pix;
    normal_data  = nd;
    loud_data    = ld;
    @(posedge basys_clock);
    #1;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 5'd31, 13'd5,   16'hA000, 16'hB000, 2'd0, 1'b0, 16'hA000, 8'd0};
    vecs[1] = '{1'b1, 1'b0, 5'd31, 13'd6,   16'hA001, 16'hB001, 2'd0, 1'b0, 16'hA001, 8'd0};
    vecs[2] = '{1'b1, 1'b1, 5'd9,  13'd7,   16'hA002, 16'hB002, 2'd0, 1'b0, 16'hA002, 8'd0};
    vecs[3] = '{1'b1, 1'b1, 5'd12, 13'd100, 16'hA003, 16'hB003, 2'd1, 1'b0, 16'hA003, 8'd1};
    vecs[4] = '{1'b1, 1'b0, 5'd0,  13'd101, 16'hA004, 16'hB004, 2'd1, 1'b0, 16'hA004, 8'd1};
    vecs[5] = '{1'b1, 1'b0, 5'd0,  13'd0,   16'hA005, 16'hB005, 2'd1, 1'b1, 16'hB005, 8'd1};
    vecs[6] = '{1'b1, 1'b1, 5'd9,  13'd1,   16'hA006, 16'hB006, 2'd1, 1'b1, 16'hB006, 8'd1};
    vecs[7] = '{1'b1, 1'b1, 5'd8,  13'd2,   16'hA007, 16'hB007, 2'd1, 1'b1, 16'hB007, 8'd1};
    vecs[8] = '{1'b1, 1'b1, 5'd7,  13'd3,   16'hA008, 16'hB008, 2'd2, 1'b1, 16'hB008, 8'd1};

    reset = 1'b1;
    drive(1'b1, 1'b1, 5'd20, 13'd0, 16'h1234, 16'h5678);
    drive(1'b1, 1'b1, 5'd20, 13'd0, 16'h1234, 16'h5678);
    check("reset_state",  32'(dut.state), 32'd0);
    check("reset_active", 32'(loud_active), 32'd0);
    check("reset_oled",   32'(oled_data), 32'd0);
    check("reset_events", 32'(loud_events), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].en, vecs[i].vv, vecs[i].vol, vecs[i].pix, vecs[i].nd, vecs[i].ld);
      check($sformatf("row%0d_state", i),  32'(dut.state),  32'(vecs[i].exp_state));
      check($sformatf("row%0d_active", i), 32'(loud_active), 32'(vecs[i].exp_active));
      check($sformatf("row%0d_oled", i),   32'(oled_data),   32'(vecs[i].exp_oled));
      check($sformatf("row%0d_events", i), 32'(loud_events), 32'(vecs[i].exp_events));
    end

    // Hold expiry: NORMAL exactly HC edges after entering HOLD.
    for (int i = 1; i <= HC; i++) begin
      drive(1'b1, 1'b0, 5'd0, 13'(3 + i), 16'hA100, 16'hB100);
      check($sformatf("hold_cyc%0d_state", i), 32'(dut.state), (i == HC) ? 32'd0 : 32'd2);
    end
    check("hold_exit_active", 32'(loud_active), 32'd1);
    check("hold_exit_oled",   32'(oled_data), 32'hB100);
    drive(1'b1, 1'b0, 5'd0, 13'd0, 16'hA101, 16'hB101);
    check("frame_release_active", 32'(loud_active), 32'd0);
    check("frame_release_oled",   32'(oled_data), 32'hA101);

    // Re-entry from HOLD on the expiry cycle.
    drive(1'b1, 1'b1, 5'd12, 13'd50, 16'hA200, 16'hB200);
    check("reenter_state",  32'(dut.state), 32'd1);
    check("reenter_events", 32'(loud_events), 32'd2);
    drive(1'b1, 1'b1, 5'd7, 13'd51, 16'hA200, 16'hB200);
    check("reenter_hold", 32'(dut.state), 32'd2);
    for (int i = 0; i < HC - 1; i++) drive(1'b1, 1'b0, 5'd0, 13'(52 + i), 16'hA200, 16'hB200);
    check("pre_expiry_count", 32'(dut.u_timer.count), 32'd15);
    check("pre_expiry_state", 32'(dut.state), 32'd2);
    drive(1'b1, 1'b1, 5'd11, 13'd70, 16'hA201, 16'hB201);
    check("rescue_state",  32'(dut.state), 32'd1);
    check("rescue_count",  32'(dut.u_timer.count), 32'd0);
    check("rescue_events", 32'(loud_events), 32'd2);
    check("rescue_active", 32'(loud_active), 32'd0);

    // Enable drop: state clears at once, display waits for frame start.
    drive(1'b1, 1'b0, 5'd0, 13'd0, 16'hA300, 16'hB300);
    check("en_pre_active", 32'(loud_active), 32'd1);
    check("en_pre_oled",   32'(oled_data), 32'hB300);
    drive(1'b0, 1'b1, 5'd20, 13'd10, 16'hA301, 16'hB301);
    check("en_drop_state",  32'(dut.state), 32'd0);
    check("en_drop_active", 32'(loud_active), 32'd1);
    check("en_drop_oled",   32'(oled_data), 32'hB301);
    drive(1'b0, 1'b0, 5'd0, 13'd8191, 16'hA302, 16'hB302);
    check("beyond_frame_active", 32'(loud_active), 32'd1);
    drive(1'b0, 1'b0, 5'd0, 13'd0, 16'hA303, 16'hB303);
    check("en_frame_active", 32'(loud_active), 32'd0);
    check("en_frame_oled",   32'(oled_data), 32'hA303);

    // Event counter saturation; level exactly ON_THRESH enters LOUD.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, 5'd10, 13'd20, 16'hA400, 16'hB400);
      drive(1'b0, 1'b0, 5'd0, 13'd21, 16'hA400, 16'hB400);
    end
    check("events_saturated", 32'(loud_events), 32'd255);

    // Reset asserted mid-HOLD with every input pushing the other way.
    drive(1'b1, 1'b1, 5'd12, 13'd30, 16'hA500, 16'hB500);
    drive(1'b1, 1'b0, 5'd0, 13'd0, 16'hA501, 16'hB501);
    check("sat_events_hold", 32'(loud_events), 32'd255);
    check("pre_reset_oled",  32'(oled_data), 32'hB501);
    drive(1'b1, 1'b1, 5'd7, 13'd1, 16'hA502, 16'hB502);
    drive(1'b1, 1'b0, 5'd0, 13'd2, 16'hA503, 16'hB503);
    drive(1'b1, 1'b0, 5'd0, 13'd3, 16'hA503, 16'hB503);
    check("pre_reset_state", 32'(dut.state), 32'd2);
    reset = 1'b1;
    drive(1'b1, 1'b1, 5'd12, 13'd0, 16'hA600, 16'hB600);
    check("midhold_reset_state",  32'(dut.state), 32'd0);
    check("midhold_reset_count",  32'(dut.u_timer.count), 32'd0);
    check("midhold_reset_active", 32'(loud_active), 32'd0);
    check("midhold_reset_oled",   32'(oled_data), 32'd0);
    check("midhold_reset_events", 32'(loud_events), 32'd0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/visualiser_mode_ctrl.md
VISUALISER_MODE_CTRL -- requirements
Module: visualiser_mode_ctrl

Interface
REQ-001 SHALL have parameter LVL_W, default 5, volume level width.
REQ-002 SHALL have parameter PIX_W, default 16, RGB565 pixel width.
REQ-003 SHALL have parameter ON_THRESH, default 10, level at or above which loud mode is requested.
REQ-004 SHALL have parameter OFF_THRESH, default 8, level below which loud mode is released; OFF_THRESH <= ON_THRESH is required.
REQ-005 SHALL have parameter HOLD_CYCLES, default 50_000_000, minimum loud dwell after release (clock cycles).
REQ-006 SHALL have parameter FRAME_LAST, default 6143, last pixel_index of a frame.
REQ-007 basys_clock  in  1  sole clock; all state changes on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 enable  in  1  loud-mode permitted (switch input); low forces normal mode.
REQ-010 volume  in  LVL_W  unsigned audio level.
REQ-011 volume_valid  in  1  one-cycle strobe qualifying volume.
REQ-012 pixel_index  in  13  current OLED pixel being requested.
REQ-013 normal_data  in  PIX_W  pixel from normal visualiser.
REQ-014 loud_data  in  PIX_W  pixel from loud image.
REQ-015 oled_data  out  PIX_W  registered selected pixel.
REQ-016 loud_active  out  1  current frame-aligned display selection (1 = loud).
REQ-017 loud_events  out  8  saturating count of NORMAL->LOUD entries.

Function
REQ-018 FSM SHALL have states NORMAL, LOUD, HOLD; reset state NORMAL.
REQ-019 NORMAL->LOUD SHALL occur on a cycle with volume_valid=1, enable=1, volume >= ON_THRESH.
REQ-020 LOUD->HOLD SHALL occur on volume_valid=1 with volume < OFF_THRESH; hold counter loads 0.
REQ-021 Levels in [OFF_THRESH, ON_THRESH) SHALL cause no transition from any state (hysteresis).
REQ-022 In HOLD the counter SHALL increment every cycle; HOLD->NORMAL when counter == HOLD_CYCLES-1.
REQ-023 In HOLD, volume_valid=1 with volume >= ON_THRESH SHALL return to LOUD and clear the counter, taking priority over hold expiry in the same cycle.
REQ-024 enable=0 SHALL force the FSM to NORMAL and clear the counter on the next edge, overriding all other transitions.
REQ-025 Samples without volume_valid SHALL be ignored; counter advances regardless of volume_valid.
REQ-026 Hold counter width SHALL be $clog2(HOLD_CYCLES) bits, minimum 1; HOLD_CYCLES=1 means HOLD lasts exactly one cycle.
REQ-027 want_loud SHALL be 1 in LOUD and HOLD, 0 in NORMAL.
REQ-028 loud_active SHALL load want_loud only on a cycle where pixel_index == 0; otherwise it holds (no mid-frame tearing).
REQ-029 oled_data SHALL be loaded each cycle with loud_data when the next-value of loud_active is 1, else normal_data: one-cycle latency, selection and pixel consistent for pixel_index 0.
REQ-030 pixel_index values above FRAME_LAST SHALL be passed through with no special handling.
REQ-031 loud_events SHALL increment on each NORMAL->LOUD transition (not HOLD->LOUD) and saturate at 255.

Reset
REQ-032 On reset: state NORMAL, counter 0, loud_active 0, oled_data 0, loud_events 0; reset overrides all other inputs, including mid-HOLD.

Structure
REQ-033 State encoding (NORMAL=0, LOUD=1, HOLD=2) and RGB565 width constant SHALL live in the shared visualiser package.
REQ-034 One sub-module, vis_hold_timer (loadable clear, increment, terminal-count flag), SHALL implement the hold counter; FSM, frame-aligned select and output register stay in the top.

Verification
REQ-035 Reset, enable=1, volume=12 valid at pixel_index=100 -> state LOUD next cycle, loud_active stays 0 until pixel_index=0, then oled_data=loud_data one cycle later.
REQ-036 In LOUD, volume=9 valid -> no transition; volume=7 valid -> HOLD; with HOLD_CYCLES=16 and no further samples -> NORMAL exactly 16 cycles after entering HOLD.
REQ-037 HOLD_CYCLES=16, volume=11 valid at counter=15 -> LOUD (not NORMAL), counter 0, loud_events unchanged.
REQ-038 In LOUD, drop enable -> NORMAL next edge; loud_active clears only at next pixel_index=0.
REQ-039 300 NORMAL->LOUD cycles -> loud_events=255; assert reset mid-HOLD -> all outputs 0, state NORMAL.
